// File: rtl/shift_pkg.sv
// Shared constants for the shift sequencer: op codes, FSM states, defaults.
package shift_pkg;

   localparam int DEF_WIDTH = 8;
   localparam int DEF_CNT_W = 4;

   localparam logic [2:0] OP_CLR  = 3'b000;
   localparam logic [2:0] OP_HOLD = 3'b001;
   localparam logic [2:0] OP_LSR  = 3'b010;
   localparam logic [2:0] OP_LSL  = 3'b011;
   localparam logic [2:0] OP_ASR  = 3'b100;
   localparam logic [2:0] OP_LIN  = 3'b101;
   localparam logic [2:0] OP_ROR  = 3'b110;
   localparam logic [2:0] OP_ROL  = 3'b111;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_RESP = 2'd2
   } state_e;

endpackage

// File: rtl/shift_seq_ctrl_if.sv
// Command/response bundle of the shift sequencer.
// Abort signals exist only with SHIFT_SEQ_ABORT_EN defined.
interface shift_seq_ctrl_if
   import shift_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int CNT_W = DEF_CNT_W
) ();

   logic             cmd_valid;
   logic             cmd_ready;
   logic [2:0]       cmd_op;
   logic [WIDTH-1:0] cmd_data;
   logic [CNT_W-1:0] cmd_cnt;
   logic             lin;
   logic             rsp_valid;
   logic             rsp_ready;
   logic [WIDTH-1:0] rsp_data;
   logic             busy;
`ifdef SHIFT_SEQ_ABORT_EN
   logic             abort;
   logic             rsp_aborted;

   modport master (
      output cmd_valid, cmd_op, cmd_data, cmd_cnt,
      output lin, rsp_ready, abort,
      input  cmd_ready, rsp_valid, rsp_data,
      input  busy, rsp_aborted
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_data, cmd_cnt,
      input  lin, rsp_ready, abort,
      output cmd_ready, rsp_valid, rsp_data,
      output busy, rsp_aborted
   );
`else
   modport master (
      output cmd_valid, cmd_op, cmd_data, cmd_cnt,
      output lin, rsp_ready,
      input  cmd_ready, rsp_valid, rsp_data, busy
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_data, cmd_cnt,
      input  lin, rsp_ready,
      output cmd_ready, rsp_valid, rsp_data, busy
   );
`endif

endinterface

// File: rtl/shift_unit.sv
// Op-coded WIDTH-bit shift register with load, clear and per-cycle step.
module shift_unit
   import shift_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [WIDTH-1:0] ld_data,
   input  logic             clr,
   input  logic             step,
   input  logic [2:0]       op,
   input  logic             lin,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] nq;

   always_comb begin
      nq = q;
      unique case (op)
         OP_CLR:  nq = '0;
         OP_HOLD: nq = q;
         OP_LSR:  nq = q >> 1;
         OP_LSL:  nq = q << 1;
         OP_ASR:  nq = {q[WIDTH-1], q[WIDTH-1:1]};
         OP_LIN:  nq = {lin, q[WIDTH-1:1]};
         OP_ROR:  nq = {q[0], q[WIDTH-1:1]};
         OP_ROL:  nq = {q[WIDTH-2:0], q[WIDTH-1]};
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         q <= '0;
      else if (clr)
         q <= '0;
      else if (load)
         q <= ld_data;
      else if (step)
         q <= nq;
   end

endmodule

// File: rtl/shift_seq_ctrl.sv
// Shift sequencer: command handshake, repeat counter and response FSM.
// Optional abort support is built with SHIFT_SEQ_ABORT_EN defined.
module shift_seq_ctrl
   import shift_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int CNT_W = DEF_CNT_W
) (
   input logic             clk,
   input logic             rst_n,
   shift_seq_ctrl_if.slave bus
);

   state_e           state;
   state_e           nxt;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;
   logic [2:0]       op_q;
   logic             hs;
   logic             step;
   logic             abort_hit;

   assign hs = bus.cmd_valid & bus.cmd_ready;

`ifdef SHIFT_SEQ_ABORT_EN
   logic aborted;

   assign abort_hit = (state == S_RUN) & bus.abort;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         aborted <= 1'b0;
      else if (hs)
         aborted <= 1'b0;
      else if (abort_hit)
         aborted <= 1'b1;
   end

   assign bus.rsp_aborted = aborted & (state == S_RESP);
`else
   assign abort_hit = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
         cnt   <= '0;
         op_q  <= OP_CLR;
      end else begin
         state <= nxt;
         cnt   <= cnt_nxt;
         if (hs)
            op_q <= bus.cmd_op;
      end
   end

   // The step that consumes the last count lands in RESP.
   always_comb begin
      nxt     = state;
      cnt_nxt = cnt;
      step    = 1'b0;
      unique case (1'b1)
         state == S_IDLE: begin
            if (hs) begin
               cnt_nxt = bus.cmd_cnt;
               nxt = (bus.cmd_cnt != '0) ? S_RUN : S_RESP;
            end
         end
         state == S_RUN: begin
            if (abort_hit) begin
               cnt_nxt = '0;
               nxt     = S_RESP;
            end else begin
               step = 1'b1;
               if (cnt <= CNT_W'(1)) begin
                  cnt_nxt = '0;
                  nxt     = S_RESP;
               end else begin
                  cnt_nxt = cnt - CNT_W'(1);
               end
            end
         end
         state == S_RESP: begin
            cnt_nxt = '0;
            if (bus.rsp_ready)
               nxt = S_IDLE;
         end
         default: begin
            cnt_nxt = '0;
            nxt     = S_IDLE;
         end
      endcase
   end

   assign bus.cmd_ready = (state == S_IDLE);
   assign bus.rsp_valid = (state == S_RESP);
   assign bus.busy      = (state == S_RUN) | (state == S_RESP);

   shift_unit #(
      .WIDTH (WIDTH)
   ) u_unit (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (hs),
      .ld_data (bus.cmd_data),
      .clr     (1'b0),
      .step    (step),
      .op      (op_q),
      .lin     (bus.lin),
      .q       (bus.rsp_data)
   );

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Directed bench for shift_seq_ctrl; abort cases need SHIFT_SEQ_ABORT_EN.
module tb_shift_seq_ctrl;
   import shift_pkg::*;

   typedef struct {
      logic [7:0]  d;
      logic [2:0]  op;
      logic [3:0]  c;
      logic [15:0] lin;
      logic [7:0]  exp;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_chk = 0;
   int   n_err = 0;

   shift_seq_ctrl_if bus ();

   shift_seq_ctrl dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   vec_t vecs[10] = '{
      '{8'h81, 3'b111, 4'd1,  16'h0000, 8'h03},
      '{8'h80, 3'b100, 4'd3,  16'h0000, 8'hF0},
      '{8'hFF, 3'b010, 4'd8,  16'hFFFF, 8'h00},
      '{8'h00, 3'b101, 4'd4,  16'h000D, 8'hD0},
      '{8'hFF, 3'b101, 4'd2,  16'h0000, 8'h3F},
      '{8'h3C, 3'b001, 4'd2,  16'hFFFF, 8'h3C},
      '{8'hAA, 3'b000, 4'd1,  16'h0000, 8'h00},
      '{8'h01, 3'b011, 4'd3,  16'h0000, 8'h08},
      '{8'h01, 3'b110, 4'd1,  16'h0000, 8'h80},
      '{8'h81, 3'b111, 4'd15, 16'h0000, 8'hC0}
   };

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_cmd(input logic [7:0] data,
                          input logic [2:0] op,
                          input logic [3:0] cnt,
                          input logic [15:0] lin_bits,
                          input int abort_at,
                          output logic [7:0] res,
                          output int lat);
      bus.cmd_data  = data;
      bus.cmd_op    = op;
      bus.cmd_cnt   = cnt;
      bus.cmd_valid = 1'b1;
      tick();
      bus.cmd_valid = 1'b0;
      bus.cmd_data  = 8'h00;
      lat = 1;
      while (!bus.rsp_valid && lat < 40) begin
         bus.lin = lin_bits[4'(lat - 1)];
`ifdef SHIFT_SEQ_ABORT_EN
         bus.abort = (lat == abort_at);
`endif
         tick();
         lat++;
      end
`ifdef SHIFT_SEQ_ABORT_EN
      bus.abort = 1'b0;
`endif
      bus.lin = 1'b0;
      res = bus.rsp_data;
   endtask

   task automatic finish_rsp();
      bus.rsp_ready = 1'b1;
      tick();
      bus.rsp_ready = 1'b0;
      chk("back_idle", 32'(bus.cmd_ready), 32'd1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog got timeout exp finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] res;
      int         lat;
      int         seen;

      bus.cmd_valid = 1'b0;
      bus.cmd_op    = 3'b000;
      bus.cmd_data  = 8'h00;
      bus.cmd_cnt   = 4'd0;
      bus.lin       = 1'b0;
      bus.rsp_ready = 1'b0;
`ifdef SHIFT_SEQ_ABORT_EN
      bus.abort     = 1'b0;
`endif
      #12;
      chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_data", 32'(bus.rsp_data), 32'h0);
      tick();
      rst_n = 1'b1;
      tick();
      chk("rel_cmd_ready", 32'(bus.cmd_ready), 32'd1);

      for (int i = 0; i < 10; i++) begin
         run_cmd(vecs[i].d, vecs[i].op, vecs[i].c,
                 vecs[i].lin, 0, res, lat);
         chk($sformatf("lat%0d", i), 32'(lat),
             32'(vecs[i].c) + 32'd1);
         chk($sformatf("data%0d", i), 32'(res),
             32'(vecs[i].exp));
`ifdef SHIFT_SEQ_ABORT_EN
         chk($sformatf("noabort%0d", i),
             32'(bus.rsp_aborted), 32'd0);
`endif
         finish_rsp();
      end

      // zero count, response held off while a new command is offered
      run_cmd(8'h5A, 3'b111, 4'd0, 16'h0, 0, res, lat);
      chk("cnt0_lat", 32'(lat), 32'd1);
      chk("cnt0_data", 32'(res), 32'h5A);
      bus.cmd_valid = 1'b1;
      bus.cmd_data  = 8'hC3;
      bus.cmd_cnt   = 4'd3;
`ifdef SHIFT_SEQ_ABORT_EN
      bus.abort     = 1'b1;
`endif
      for (int i = 0; i < 5; i++) begin
         chk("hold_valid", 32'(bus.rsp_valid), 32'd1);
         chk("hold_data", 32'(bus.rsp_data), 32'h5A);
         chk("hold_ready", 32'(bus.cmd_ready), 32'd0);
         tick();
      end
      bus.cmd_valid = 1'b0;
`ifdef SHIFT_SEQ_ABORT_EN
      chk("abort_resp_ign", 32'(bus.rsp_aborted), 32'd0);
      bus.abort = 1'b0;
`endif
      finish_rsp();
      chk("idle_data", 32'(bus.rsp_data), 32'h5A);

      // reset in the middle of a long run
      bus.cmd_data  = 8'h81;
      bus.cmd_op    = 3'b111;
      bus.cmd_cnt   = 4'd15;
      bus.cmd_valid = 1'b1;
      tick();
      bus.cmd_valid = 1'b0;
      tick();
      tick();
      tick();
      chk("mid_busy", 32'(bus.busy), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_ready", 32'(bus.cmd_ready), 32'd1);
      chk("mid_rst_busy", 32'(bus.busy), 32'd0);
      chk("mid_rst_valid", 32'(bus.rsp_valid), 32'd0);
      chk("mid_rst_data", 32'(bus.rsp_data), 32'h0);
      tick();
      tick();
      rst_n = 1'b1;
      seen = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (bus.rsp_valid || bus.busy)
            seen++;
      end
      chk("no_rsp_after_rst", 32'(seen), 32'd0);
      chk("post_rst_ready", 32'(bus.cmd_ready), 32'd1);

`ifdef SHIFT_SEQ_ABORT_EN
      run_cmd(8'h01, 3'b011, 4'd10, 16'h0, 3, res, lat);
      chk("abort_lat", 32'(lat), 32'd4);
      chk("abort_data", 32'(res), 32'h04);
      chk("abort_flag", 32'(bus.rsp_aborted), 32'd1);
      finish_rsp();
`endif

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
